// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, shift function codes,
// shifter control encodings and register-number width.
package mips_pkg;

  // Register-number width (32 architectural registers)
  localparam int REG_W = 5;

  // Primary opcode shared by all R-type instructions
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  // R-type function codes for the shift group
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  // Barrel shifter control: 00 arithmetic right, 01 logical right, 1x left
  typedef enum logic [1:0] {
    ALUC_SRA = 2'b00,
    ALUC_SRL = 2'b01,
    ALUC_SLL = 2'b11
  } aluc_e;

endpackage

// File: rtl/barrelshifter32.sv
// Combinational 32-bit barrel shifter.
// aluc selects arithmetic right (00), logical right (01) or left (1x);
// b is the 5-bit shift amount, so no carry or overflow leaves the unit.
module barrelshifter32
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  aluc,
  output logic [31:0] c
);

  // Select the shift flavour; left shift covers both 1x encodings
  always_comb begin
    c = a << b;
    case (aluc)
      ALUC_SRA: c = $signed(a) >>> b;
      ALUC_SRL: c = a >> b;
      default:  c = a << b;
    endcase
  end

endmodule

// File: rtl/ex_shift_stage.sv
// Execute-stage shift unit. Captures decoded shift instructions from ID
// (with MEM/WB operand forwarding) into E, shifts, and registers the
// result into M toward the MEM stage. Valid/ready on both sides; flush
// kills the E entry and any same-cycle capture but never the older M entry.
module ex_shift_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic          fwd_mem_en,
  input  logic [RW-1:0] fwd_mem_rd,
  input  logic [DW-1:0] fwd_mem_data,
  input  logic          fwd_wb_en,
  input  logic [RW-1:0] fwd_wb_rd,
  input  logic [DW-1:0] fwd_wb_data,
  input  logic          flush,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_result,
  output logic [RW-1:0] mem_rd,
  output logic [DW-1:0] mem_pc,
  output logic          mem_is_shift
);

  // Shift-amount width follows the datapath width (5 bits for 32)
  localparam int SHW = $clog2(DW);

  // Instruction fields
  logic [5:0]     opcode;
  logic [5:0]     funct;
  logic [RW-1:0]  rs_num;
  logic [RW-1:0]  rt_num;
  logic [RW-1:0]  rd_num;
  logic [SHW-1:0] shamt;

  assign opcode = id_instr[31:26];
  assign rs_num = id_instr[25:21];
  assign rt_num = id_instr[20:16];
  assign rd_num = id_instr[15:11];
  assign shamt  = id_instr[10:6];
  assign funct  = id_instr[5:0];

  // Forwarded operands and decode results for the instruction offered by ID
  logic [DW-1:0]  rs_fwd;
  logic [DW-1:0]  rt_fwd;
  logic           dec_shift;
  logic           dec_var;
  logic [1:0]     dec_aluc;
  logic [SHW-1:0] dec_b;
  logic [RW-1:0]  dec_rd;

  // E register contents
  logic           e_valid;
  logic [DW-1:0]  e_a;
  logic [SHW-1:0] e_b;
  logic [1:0]     e_aluc;
  logic           e_shift;
  logic [RW-1:0]  e_rd;
  logic [DW-1:0]  e_pc;

  // Handshake terms
  logic m_free;
  logic id_fire;
  logic e_to_m;
  logic [DW-1:0] sh_c;

  assign m_free   = !mem_valid || mem_ready;
  assign id_ready = !e_valid || m_free;
  assign id_fire  = id_valid && id_ready && !flush;
  assign e_to_m   = e_valid && m_free && !flush;

  // Pick rs/rt from MEM, then WB, then the register file; $0 never forwards
  always_comb begin
    rs_fwd = id_rs_val;
    rt_fwd = id_rt_val;
    if (rs_num != '0) begin
      if (fwd_mem_en && (fwd_mem_rd == rs_num)) begin
        rs_fwd = fwd_mem_data;
      end else if (fwd_wb_en && (fwd_wb_rd == rs_num)) begin
        rs_fwd = fwd_wb_data;
      end
    end
    if (rt_num != '0) begin
      if (fwd_mem_en && (fwd_mem_rd == rt_num)) begin
        rt_fwd = fwd_mem_data;
      end else if (fwd_wb_en && (fwd_wb_rd == rt_num)) begin
        rt_fwd = fwd_wb_data;
      end
    end
  end

  // Decode the shift group; anything else becomes a no-writeback bubble
  always_comb begin
    dec_shift = 1'b0;
    dec_var   = 1'b0;
    dec_aluc  = ALUC_SLL;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FUNCT_SLL:  begin dec_shift = 1'b1; dec_aluc = ALUC_SLL; end
        FUNCT_SRL:  begin dec_shift = 1'b1; dec_aluc = ALUC_SRL; end
        FUNCT_SRA:  begin dec_shift = 1'b1; dec_aluc = ALUC_SRA; end
        FUNCT_SLLV: begin dec_shift = 1'b1; dec_var = 1'b1; dec_aluc = ALUC_SLL; end
        FUNCT_SRLV: begin dec_shift = 1'b1; dec_var = 1'b1; dec_aluc = ALUC_SRL; end
        FUNCT_SRAV: begin dec_shift = 1'b1; dec_var = 1'b1; dec_aluc = ALUC_SRA; end
        default:    dec_shift = 1'b0;
      endcase
    end
    dec_b  = dec_var ? SHW'(rs_fwd) : shamt;
    dec_rd = dec_shift ? rd_num : '0;
  end

  // E register: flush empties it, otherwise load from ID or drain into M
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_aluc  <= ALUC_SLL;
      e_shift <= 1'b0;
      e_rd    <= '0;
      e_pc    <= '0;
    end else begin
      if (flush) begin
        e_valid <= 1'b0;
      end else if (id_fire) begin
        e_valid <= 1'b1;
      end else if (e_to_m) begin
        e_valid <= 1'b0;
      end
      if (id_fire) begin
        e_a     <= rt_fwd;
        e_b     <= dec_b;
        e_aluc  <= dec_aluc;
        e_shift <= dec_shift;
        e_rd    <= dec_rd;
        e_pc    <= id_pc;
      end
    end
  end

  barrelshifter32 u_shift (
    .a    (e_a),
    .b    (e_b),
    .aluc (e_aluc),
    .c    (sh_c)
  );

  // M register: reload from E when free, hold bit-stable while MEM stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      mem_result   <= '0;
      mem_rd       <= '0;
      mem_pc       <= '0;
      mem_is_shift <= 1'b0;
    end else if (e_to_m) begin
      mem_valid    <= 1'b1;
      mem_result   <= e_shift ? sh_c : '0;
      mem_rd       <= e_rd;
      mem_pc       <= e_pc;
      mem_is_shift <= e_shift;
    end else if (mem_valid && mem_ready) begin
      mem_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_shift_stage.sv
// Self-checking bench for ex_shift_stage: directed steps plus a short
// random run, with expected results queued at acceptance and compared
// whenever M holds a result.
module tb_ex_shift_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        fwd_mem_en;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        fwd_wb_en;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_data;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic [4:0]  mem_rd;
  logic [31:0] mem_pc;
  logic        mem_is_shift;

  ex_shift_stage dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_rs_val    (id_rs_val),
    .id_rt_val    (id_rt_val),
    .fwd_mem_en   (fwd_mem_en),
    .fwd_mem_rd   (fwd_mem_rd),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_en    (fwd_wb_en),
    .fwd_wb_rd    (fwd_wb_rd),
    .fwd_wb_data  (fwd_wb_data),
    .flush        (flush),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_result   (mem_result),
    .mem_rd       (mem_rd),
    .mem_pc       (mem_pc),
    .mem_is_shift (mem_is_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        is_shift;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pcCount = 32'h0000_1000;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  // Reference behaviour of one instruction with forwarding inactive
  function automatic void refModel(input logic [31:0] instr, input logic [31:0] rsv,
                                   input logic [31:0] rtv, output logic [31:0] res,
                                   output logic [4:0] rd, output logic sh);
    res = 32'h0;
    sh  = 1'b0;
    if (instr[31:26] == 6'b000000) begin
      sh = 1'b1;
      case (instr[5:0])
        6'b000000: res = rtv << instr[10:6];
        6'b000010: res = rtv >> instr[10:6];
        6'b000011: res = $signed(rtv) >>> instr[10:6];
        6'b000100: res = rtv << rsv[4:0];
        6'b000110: res = rtv >> rsv[4:0];
        6'b000111: res = $signed(rtv) >>> rsv[4:0];
        default:   sh = 1'b0;
      endcase
    end
    rd = sh ? instr[15:11] : 5'd0;
  endfunction

  // Offer one instruction; call at posedge+1, returns at posedge+1 after acceptance
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rsv,
                               input logic [31:0] rtv, input logic [31:0] expResult,
                               input logic [4:0] expRd, input logic expShift);
    exp_t e;
    bit   accepted = 1'b0;
    id_valid   = 1'b1;
    id_instr   = instr;
    id_rs_val  = rsv;
    id_rt_val  = rtv;
    id_pc      = pcCount;
    e.result   = expResult;
    e.rd       = expRd;
    e.pc       = pcCount;
    e.is_shift = expShift;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (id_ready && !flush) begin
        sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    id_valid = 1'b0;
    pcCount  = pcCount + 32'd4;
    checkOutput("accepted", 32'(accepted), 32'd1);
  endtask

  // Wait (bounded) for every queued result to retire and M to empty
  task automatic waitDrain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mem_valid) done = 1'b1;
    end
    checkOutput({tag, "_drain"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Compare M against the oldest expected entry every cycle it is valid
  always @(negedge clk) begin
    if (!rst && mem_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'(mem_valid), 32'd0);
      end else begin
        mon = sb[0];
        checkOutput("mem_result", mem_result, mon.result);
        checkOutput("mem_rd", 32'(mem_rd), 32'(mon.rd));
        checkOutput("mem_pc", mem_pc, mon.pc);
        checkOutput("mem_is_shift", 32'(mem_is_shift), 32'(mon.is_shift));
        if (mem_ready) void'(sb.pop_front());
      end
    end
  end

  logic [5:0]  functs [7] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100,
                               6'b000110, 6'b000111, 6'b100000};

  initial begin
    logic [31:0] rinstr, rrs, rrt, rres;
    logic [4:0]  rrd;
    logic        rsh;

    rst = 1'b1;
    id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs_val = '0; id_rt_val = '0;
    fwd_mem_en = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_en = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    flush = 1'b0; mem_ready = 1'b1;

    #12;
    $display("[TB] reset state");
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_mem_result", mem_result, 32'd0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_pc", mem_pc, 32'd0);
    checkOutput("rst_mem_is_shift", 32'(mem_is_shift), 32'd0);
    checkOutput("rst_id_ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] SLL shamt 31 and two-edge latency");
    applyStimulus(rtype(5'd0, 5'd2, 5'd3, 5'd31, FUNCT_SLL), 32'hFFFF_FFFF,
                  32'h0000_0001, 32'h8000_0000, 5'd3, 1'b1);
    @(negedge clk);
    checkOutput("lat_after_edge1", 32'(mem_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lat_after_edge2", 32'(mem_valid), 32'd1);
    @(posedge clk);
    #1;
    waitDrain("sll31");

    $display("[TB] variable shifts use rs low bits only");
    applyStimulus(rtype(5'd4, 5'd5, 5'd6, 5'd3, FUNCT_SRAV), 32'h0000_0025,
                  32'h8000_0000, 32'hFC00_0000, 5'd6, 1'b1);
    applyStimulus(rtype(5'd4, 5'd5, 5'd7, 5'd0, FUNCT_SRLV), 32'h0000_0025,
                  32'h8000_0000, 32'h0400_0000, 5'd7, 1'b1);
    waitDrain("var");

    $display("[TB] back-to-back with MEM stall");
    applyStimulus(rtype(5'd0, 5'd9, 5'd10, 5'd4, FUNCT_SRL), 32'h0,
                  32'hF000_000F, 32'h0F00_0000, 5'd10, 1'b1);
    applyStimulus(rtype(5'd0, 5'd11, 5'd12, 5'd8, FUNCT_SLL), 32'h0,
                  32'h0000_00FF, 32'h0000_FF00, 5'd12, 1'b1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_id_ready", 32'(id_ready), 32'd0);
      checkOutput("stall_mem_valid", 32'(mem_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    waitDrain("stall");

    $display("[TB] forwarding priority");
    fwd_mem_en = 1'b1; fwd_mem_rd = 5'd8; fwd_mem_data = 32'h0000_1234;
    fwd_wb_en = 1'b1; fwd_wb_rd = 5'd8; fwd_wb_data = 32'h0000_FFFF;
    applyStimulus(rtype(5'd0, 5'd8, 5'd13, 5'd4, FUNCT_SLL), 32'h0,
                  32'hDEAD_0000, 32'h0001_2340, 5'd13, 1'b1);
    fwd_mem_rd = 5'd9;
    applyStimulus(rtype(5'd0, 5'd8, 5'd13, 5'd4, FUNCT_SLL), 32'h0,
                  32'hDEAD_0000, 32'h000F_FFF0, 5'd13, 1'b1);
    fwd_mem_rd = 5'd7; fwd_mem_data = 32'hFFFF_FFE2;
    fwd_wb_rd = 5'd14; fwd_wb_data = 32'h0000_0003;
    applyStimulus(rtype(5'd7, 5'd14, 5'd15, 5'd0, FUNCT_SLLV), 32'h0000_001F,
                  32'h0000_0001, 32'h0000_000C, 5'd15, 1'b1);
    fwd_mem_rd = 5'd0; fwd_mem_data = 32'h0000_5555;
    fwd_wb_rd = 5'd0; fwd_wb_data = 32'h0000_7777;
    applyStimulus(rtype(5'd0, 5'd0, 5'd16, 5'd1, FUNCT_SLL), 32'h0,
                  32'h0000_0003, 32'h0000_0006, 5'd16, 1'b1);
    fwd_mem_en = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_en = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    waitDrain("fwd");

    $display("[TB] non-shift and boundary shift amounts");
    applyStimulus(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'b100000), 32'h1111_1111,
                  32'h2222_2222, 32'h0, 5'd0, 1'b0);
    applyStimulus({6'b001000, 5'd1, 5'd2, 5'd10, 5'd4, FUNCT_SLL}, 32'h1,
                  32'h0000_00FF, 32'h0, 5'd0, 1'b0);
    applyStimulus(rtype(5'd0, 5'd3, 5'd4, 5'd0, FUNCT_SLL), 32'h0,
                  32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd4, 1'b1);
    applyStimulus(rtype(5'd0, 5'd3, 5'd5, 5'd31, FUNCT_SRA), 32'h0,
                  32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1'b1);
    applyStimulus(rtype(5'd0, 5'd3, 5'd6, 5'd31, FUNCT_SRL), 32'h0,
                  32'h8000_0000, 32'h0000_0001, 5'd6, 1'b1);
    waitDrain("edge");

    $display("[TB] flush with E full and M stalled");
    mem_ready = 1'b0;
    applyStimulus(rtype(5'd0, 5'd2, 5'd17, 5'd1, FUNCT_SLL), 32'h0,
                  32'h0000_0040, 32'h0000_0080, 5'd17, 1'b1);
    applyStimulus(rtype(5'd0, 5'd2, 5'd18, 5'd2, FUNCT_SLL), 32'h0,
                  32'h0000_0001, 32'h0000_0004, 5'd18, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_id_ready_full", 32'(id_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    checkOutput("flush_e_empty", 32'(id_ready), 32'd1);
    checkOutput("flush_m_kept", 32'(mem_valid), 32'd1);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    waitDrain("flush");

    $display("[TB] flush blocks same-cycle capture");
    flush = 1'b1;
    id_valid = 1'b1;
    id_instr = rtype(5'd0, 5'd2, 5'd19, 5'd1, FUNCT_SLL);
    id_rt_val = 32'h0000_0001;
    @(posedge clk);
    #1;
    flush = 1'b0;
    id_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("flush_no_capture", 32'(mem_valid), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] random shifts");
    for (int i = 0; i < 10; i++) begin
      rrs = $urandom;
      rrt = $urandom;
      rinstr = rtype(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
                     functs[$urandom_range(0, 6)]);
      refModel(rinstr, rrs, rrt, rres, rrd, rsh);
      applyStimulus(rinstr, rrs, rrt, rres, rrd, rsh);
    end
    waitDrain("random");

    $display("[TB] reset mid-stream");
    mem_ready = 1'b0;
    applyStimulus(rtype(5'd0, 5'd2, 5'd20, 5'd1, FUNCT_SLL), 32'h0,
                  32'h0000_0001, 32'h0000_0002, 5'd20, 1'b1);
    applyStimulus(rtype(5'd0, 5'd2, 5'd21, 5'd2, FUNCT_SLL), 32'h0,
                  32'h0000_0001, 32'h0000_0004, 5'd21, 1'b1);
    checkOutput("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    checkOutput("pre_rst_id_ready", 32'(id_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("async_rst_mem_result", mem_result, 32'd0);
    checkOutput("async_rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("async_rst_mem_is_shift", 32'(mem_is_shift), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("post_rst_id_ready", 32'(id_ready), 32'd1);
    checkOutput("post_rst_mem_valid", 32'(mem_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(rtype(5'd0, 5'd2, 5'd22, 5'd3, FUNCT_SLL), 32'h0,
                  32'h0000_0001, 32'h0000_0008, 5'd22, 1'b1);
    waitDrain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
